// File: rtl/popcount_stats_pkg.sv
// Shared types and width derivations for the popcount statistics path.
// The top-level popcount wrapper uses the same helpers so the widths always agree.
package popcount_stats_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Count range is 0..width inclusive, hence the extra bit.
   function automatic int unsigned cnt_w(int unsigned width);
      return $clog2(width) + 1;
   endfunction

   function automatic int unsigned wcnt_w(int unsigned max_words);
      return $clog2(max_words) + 1;
   endfunction

   function automatic int unsigned sum_w(int unsigned width, int unsigned max_words);
      return cnt_w(width) + $clog2(max_words);
   endfunction

endpackage

// File: rtl/popcount_frame_stats_if.sv
// Count stream in, per-frame statistics out. Master drives the counts,
// slave (the stats block) drives the results.
interface popcount_frame_stats_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_WORDS = 256
);
   localparam int unsigned CNT_W  = popcount_stats_pkg::cnt_w(WIDTH);
   localparam int unsigned WCNT_W = popcount_stats_pkg::wcnt_w(MAX_WORDS);
   localparam int unsigned SUM_W  = popcount_stats_pkg::sum_w(WIDTH, MAX_WORDS);

   logic [CNT_W-1:0]  cnt_i;
   logic              cnt_val_i;
   logic              last_i;
   logic [SUM_W-1:0]  sum_o;
   logic [CNT_W-1:0]  min_o;
   logic [CNT_W-1:0]  max_o;
   logic [WCNT_W-1:0] words_o;
   logic              ovf_o;
   logic              stats_val_o;

   modport master (
      output cnt_i, cnt_val_i, last_i,
      input  sum_o, min_o, max_o, words_o, ovf_o, stats_val_o
   );

   modport slave (
      input  cnt_i, cnt_val_i, last_i,
      output sum_o, min_o, max_o, words_o, ovf_o, stats_val_o
   );
endinterface

// File: rtl/popcount_frame_stats.sv
// Reduces each frame of popcounts to sum/min/max/word count, one result pulse per frame.
// Frames reaching MAX_WORDS without last are reported truncated and their tail discarded.
module popcount_frame_stats
   import popcount_stats_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_WORDS = 256
) (
   input logic                   clk_i,
   input logic                   rst_n_i,
   popcount_frame_stats_if.slave bus
);
   localparam int unsigned CNT_W  = cnt_w(WIDTH);
   localparam int unsigned WCNT_W = wcnt_w(MAX_WORDS);
   localparam int unsigned SUM_W  = sum_w(WIDTH, MAX_WORDS);

   state_t state_q, state_d;

   logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
   logic [CNT_W-1:0]  acc_min_q, acc_min_d;
   logic [CNT_W-1:0]  acc_max_q, acc_max_d;
   logic [WCNT_W-1:0] acc_words_q, acc_words_d;

   logic [SUM_W-1:0]  sum_q;
   logic [CNT_W-1:0]  min_q, max_q;
   logic [WCNT_W-1:0] words_q;
   logic              ovf_q, ovf_d;
   logic              val_q;

   logic first, cap_hit, load, emit;

   // A word seen in IDLE starts a fresh frame, so it replaces rather than merges.
   always_comb begin
      first       = (state_q == IDLE);
      acc_sum_d   = first ? SUM_W'(bus.cnt_i) : acc_sum_q + SUM_W'(bus.cnt_i);
      acc_min_d   = (first || bus.cnt_i < acc_min_q) ? bus.cnt_i : acc_min_q;
      acc_max_d   = (first || bus.cnt_i > acc_max_q) ? bus.cnt_i : acc_max_q;
      acc_words_d = first ? WCNT_W'(1) : acc_words_q + WCNT_W'(1);
      cap_hit     = (acc_words_d == WCNT_W'(MAX_WORDS));
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      emit    = 1'b0;
      ovf_d   = 1'b0;
      unique case (state_q)
         IDLE, ACC: begin
            if (bus.cnt_val_i) begin
               load = 1'b1;
               if (bus.last_i) begin
                  emit    = 1'b1;
                  state_d = IDLE;
               end else if (cap_hit) begin
                  emit    = 1'b1;
                  ovf_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  state_d = ACC;
               end
            end
         end
         DRAIN: begin
            if (bus.cnt_val_i && bus.last_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         acc_sum_q   <= '0;
         acc_min_q   <= '0;
         acc_max_q   <= '0;
         acc_words_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            acc_sum_q   <= acc_sum_d;
            acc_min_q   <= acc_min_d;
            acc_max_q   <= acc_max_d;
            acc_words_q <= acc_words_d;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sum_q   <= '0;
         min_q   <= '0;
         max_q   <= '0;
         words_q <= '0;
         ovf_q   <= 1'b0;
         val_q   <= 1'b0;
      end else begin
         val_q <= emit;
         if (emit) begin
            sum_q   <= acc_sum_d;
            min_q   <= acc_min_d;
            max_q   <= acc_max_d;
            words_q <= acc_words_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   assign bus.sum_o       = sum_q;
   assign bus.min_o       = min_q;
   assign bus.max_o       = max_q;
   assign bus.words_o     = words_q;
   assign bus.ovf_o       = ovf_q;
   assign bus.stats_val_o = val_q;

endmodule
